// File: rtl/mii_rx_pkg.sv
// Shared types and constants for the MII receive framer.
package mii_rx_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    DATA     = 2'd2,
    DROP     = 2'd3
  } state_e;

  localparam logic [3:0]  PREAMBLE_NIB      = 4'h5;
  localparam logic [3:0]  SFD_NIB           = 4'hD;
  localparam int unsigned MAX_FRAME_LEN_DEF = 1518;
  localparam int unsigned BYTE_CNT_W        = 11;

endpackage

// File: rtl/mii_rx_framer_if.sv
// MII receive pins plus the write side of the PHY RX FIFO.
interface mii_rx_framer_if;

  logic [3:0] mii_rxd;
  logic       mii_rx_dv;
  logic       mii_rx_er;
  logic [7:0] o_fifo_din;
  logic       o_fifo_del;
  logic       o_fifo_wren;
  logic       o_fifo_afull;

  modport master (
    output mii_rxd, mii_rx_dv, mii_rx_er, o_fifo_afull,
    input  o_fifo_din, o_fifo_del, o_fifo_wren
  );

  modport slave (
    input  mii_rxd, mii_rx_dv, mii_rx_er, o_fifo_afull,
    output o_fifo_din, o_fifo_del, o_fifo_wren
  );

endinterface

// File: rtl/sat_cnt16.sv
// 16-bit event counter that sticks at all-ones.
module sat_cnt16 (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        inc_i,
  output logic [15:0] cnt_o
);

  logic [15:0] cnt_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)                          cnt_q <= 16'h0000;
    else if (inc_i && cnt_q != 16'hFFFF)  cnt_q <= cnt_q + 16'd1;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/mii_rx_framer.sv
// Assembles MII nibbles into bytes and writes frames into the PHY RX FIFO,
// delaying each byte by one so the last byte can carry the delimiter.
module mii_rx_framer
  import mii_rx_pkg::*;
#(
  parameter int unsigned MAX_FRAME_LEN = MAX_FRAME_LEN_DEF
) (
  input  logic                  clk,
  input  logic                  arst_n,
  mii_rx_framer_if.slave        bus,
  output logic [15:0]           rx_frame_cnt,
  output logic [15:0]           rx_drop_cnt
);

  state_e                  state_q, state_d;
  logic                    armed_q, armed_d;
  logic                    seen5_q, seen5_d;
  logic                    phase_q, phase_d;
  logic [3:0]              low_q, low_d;
  logic [7:0]              hold_q, hold_d;
  logic                    hold_vld_q, hold_vld_d;
  logic                    pend_q, pend_d;
  logic [BYTE_CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]              din_q, din_d;
  logic                    del_q, del_d;
  logic                    wren_q, wren_d;
  logic                    fin_c, frame_inc_c, drop_inc_c;
  logic [7:0]              new_byte_c;
  logic [BYTE_CNT_W:0]     byte_num_c;

  assign new_byte_c = {bus.mii_rxd, low_q};
  assign byte_num_c = {1'b0, cnt_q} + (BYTE_CNT_W+1)'(1);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= IDLE;
      armed_q    <= 1'b0;
      seen5_q    <= 1'b0;
      phase_q    <= 1'b0;
      low_q      <= 4'h0;
      hold_q     <= 8'h00;
      hold_vld_q <= 1'b0;
      pend_q     <= 1'b0;
      cnt_q      <= '0;
      din_q      <= 8'h00;
      del_q      <= 1'b0;
      wren_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      armed_q    <= armed_d;
      seen5_q    <= seen5_d;
      phase_q    <= phase_d;
      low_q      <= low_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      pend_q     <= pend_d;
      cnt_q      <= cnt_d;
      din_q      <= din_d;
      del_q      <= del_d;
      wren_q     <= wren_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    armed_d     = armed_q | ~bus.mii_rx_dv;
    seen5_d     = seen5_q;
    phase_d     = phase_q;
    low_d       = low_q;
    hold_d      = hold_q;
    hold_vld_d  = hold_vld_q;
    pend_d      = 1'b0;
    cnt_d       = cnt_q;
    din_d       = din_q;
    del_d       = 1'b0;
    wren_d      = 1'b0;
    fin_c       = 1'b0;
    frame_inc_c = 1'b0;
    drop_inc_c  = 1'b0;

    // Closing write deferred by one cycle to keep writes two clocks apart
    if (pend_q) begin
      din_d      = hold_q;
      del_d      = 1'b1;
      wren_d     = 1'b1;
      hold_vld_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (bus.mii_rx_dv && armed_q) begin
          state_d = PREAMBLE;
          seen5_d = (bus.mii_rxd == PREAMBLE_NIB);
        end
      end
      PREAMBLE: begin
        if (!bus.mii_rx_dv) begin
          state_d = IDLE;
        end else if (bus.mii_rxd == PREAMBLE_NIB) begin
          seen5_d = 1'b1;
        end else if (bus.mii_rxd == SFD_NIB && seen5_q) begin
          if (bus.o_fifo_afull) begin
            state_d    = DROP;
            drop_inc_c = 1'b1;
          end else begin
            state_d    = DATA;
            phase_d    = 1'b0;
            cnt_d      = '0;
            hold_vld_d = 1'b0;
          end
        end else begin
          state_d = DROP;
        end
      end
      DATA: begin
        if (bus.mii_rx_er) begin
          fin_c      = hold_vld_q;
          drop_inc_c = 1'b1;
          state_d    = DROP;
        end else if (!bus.mii_rx_dv) begin
          fin_c       = hold_vld_q;
          frame_inc_c = hold_vld_q;
          state_d     = IDLE;
        end else if (!phase_q) begin
          low_d   = bus.mii_rxd;
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          cnt_d   = (&cnt_q) ? cnt_q : cnt_q + BYTE_CNT_W'(1);
          if (byte_num_c == (BYTE_CNT_W+1)'(MAX_FRAME_LEN + 1)) begin
            fin_c      = hold_vld_q;
            drop_inc_c = 1'b1;
            state_d    = DROP;
          end else if (hold_vld_q && bus.o_fifo_afull) begin
            fin_c      = 1'b1;
            drop_inc_c = 1'b1;
            state_d    = DROP;
          end else begin
            if (hold_vld_q) begin
              din_d  = hold_q;
              wren_d = 1'b1;
            end
            hold_d     = new_byte_c;
            hold_vld_d = 1'b1;
          end
        end
      end
      DROP: begin
        if (!bus.mii_rx_dv) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Final byte of a frame carries the delimiter
    if (fin_c) begin
      if (wren_q) begin
        pend_d = 1'b1;
      end else begin
        din_d      = hold_q;
        del_d      = 1'b1;
        wren_d     = 1'b1;
        hold_vld_d = 1'b0;
      end
    end
  end

  assign bus.o_fifo_din  = din_q;
  assign bus.o_fifo_del  = del_q;
  assign bus.o_fifo_wren = wren_q;

  sat_cnt16 u_frame_cnt (
    .clk    (clk),
    .arst_n (arst_n),
    .inc_i  (frame_inc_c),
    .cnt_o  (rx_frame_cnt)
  );

  sat_cnt16 u_drop_cnt (
    .clk    (clk),
    .arst_n (arst_n),
    .inc_i  (drop_inc_c),
    .cnt_o  (rx_drop_cnt)
  );

endmodule

// File: doc/mii_rx_framer.md
MII_RX_FRAMER -- requirements
Module: mii_rx_framer

Interface
REQ-001 SHALL have parameter MAX_FRAME_LEN, default 1518: maximum bytes per frame after SFD, including FCS.
REQ-002 SHALL have ports clk, input, 1: single clock, the MII RX clock; all other inputs are synchronous to it.
REQ-003 SHALL have ports arst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have ports mii_rxd, input, 4: receive nibble, low nibble of each byte first.
REQ-005 SHALL have ports mii_rx_dv, input, 1: receive data valid.
REQ-006 SHALL have ports mii_rx_er, input, 1: receive error.
REQ-007 SHALL have ports o_fifo_din, output, 8: byte to the PHY RX FIFO.
REQ-008 SHALL have ports o_fifo_del, output, 1: delimiter; marks the last byte of a frame and is written with that byte.
REQ-009 SHALL have ports o_fifo_wren, output, 1: write strobe.
REQ-010 SHALL have ports o_fifo_afull, input, 1: FIFO almost full, meaning at least 2 entries are free while it is deasserted.
REQ-011 SHALL have ports rx_frame_cnt, output, 16: count of frames delivered complete, saturating.
REQ-012 SHALL have ports rx_drop_cnt, output, 16: count of frames truncated or dropped, saturating.

Function
REQ-013 SHALL have states IDLE, PREAMBLE, DATA, DROP.
REQ-014 In IDLE, SHALL go to PREAMBLE on mii_rx_dv=1 only when armed; armed is set by sampling mii_rx_dv=0 at least once.
REQ-015 In PREAMBLE:
- nibble 0x5: stay in PREAMBLE.
- nibble 0xD after at least one 0x5: go to DATA, nibble phase 0.
- any other nibble: go to DROP.
- mii_rx_dv=0: go to IDLE; nothing is written and no counter changes.
REQ-016 On entry to DATA with o_fifo_afull=1, SHALL go to DROP instead, increment rx_drop_cnt, and write nothing for the frame.
REQ-017 In DATA, nibble assembly:
- phase 0: latch the low nibble.
- phase 1: form byte {mii_rxd, low}.
REQ-018 SHALL keep a one-byte hold register; when a byte completes with the hold register valid, SHALL write the held byte with del=0 and then load the new byte into hold.
REQ-019 On mii_rx_dv=0 in DATA with the hold register valid, SHALL write the held byte with del=1, increment rx_frame_cnt and go to IDLE; a dangling odd nibble is discarded.
REQ-020 On mii_rx_dv=0 in DATA with the hold register empty, SHALL go to IDLE with no write and no counter change.
REQ-021 Truncation SHALL occur on any of:
- mii_rx_er=1 in DATA;
- completion of byte MAX_FRAME_LEN+1;
- o_fifo_afull=1 when a del=0 write is due.
REQ-022 On truncation, SHALL write the held byte (if valid) with del=1 in place of any del=0 write, increment rx_drop_cnt and go to DROP; the downstream CRC check then fails the frame.
REQ-023 In DROP, SHALL write nothing and go to IDLE on mii_rx_dv=0.
REQ-024 Outputs o_fifo_din, o_fifo_del and o_fifo_wren SHALL be registered; o_fifo_wren is a one-cycle pulse in the cycle after the triggering sample.
REQ-025 SHALL issue at most one write per 2 clocks.
REQ-026 SHALL hold o_fifo_del=0 whenever o_fifo_wren=0.
REQ-027 The byte counter SHALL be 11 bits, SHALL clear on PREAMBLE-to-DATA entry, and SHALL saturate at 2047.
REQ-028 Simultaneous mii_rx_er and mii_rx_dv falling SHALL be treated as truncation, not as a normal end.
REQ-029 Counters SHALL hold at 16'hFFFF once saturated.

Reset
REQ-030 On arst_n=0, SHALL set:
- state to IDLE;
- armed=0 and hold register invalid;
- o_fifo_din=0, o_fifo_del=0, o_fifo_wren=0;
- both counters to 0.
REQ-031 Reset mid-frame SHALL emit no delimiter; the remainder of that frame SHALL be ignored until mii_rx_dv is sampled low.

Structure
REQ-032 Package mii_rx_pkg SHALL hold:
- the state enum;
- PREAMBLE_NIB=4'h5 and SFD_NIB=4'hD;
- the default for MAX_FRAME_LEN.
REQ-033 Sub-module sat_cnt16 (saturating 16-bit counter with increment enable) SHALL be instantiated twice, for rx_frame_cnt and rx_drop_cnt.

Verification
REQ-034 Normal 64-byte frame, 7x55 preamble, D5 SFD -> 64 writes, del=1 only on byte 64, bytes in order, rx_frame_cnt=1.
REQ-035 mii_rx_er=1 during byte 20 -> last write is byte 19 with del=1, then no writes until mii_rx_dv falls, rx_drop_cnt=1.
REQ-036 1600-byte frame with MAX_FRAME_LEN=1518 -> exactly 1518 writes, del=1 on write 1518, rx_drop_cnt=1.
REQ-037 o_fifo_afull=1 at SFD -> zero writes, rx_drop_cnt=1; o_fifo_afull asserted at byte 100 -> byte 99 written with del=1.
REQ-038 arst_n pulsed low mid-frame, mii_rx_dv held high -> no writes until mii_rx_dv low then a new preamble; next frame delivered intact.
REQ-039 Frame of 1 byte plus an odd dribble nibble -> single write with del=1; preamble containing nibble 0x3 -> DROP, zero writes.
